// File: rtl/jtag_debug_pkg.sv
// Shared types and width helpers for the JTAG debug command bridge.
package jtag_debug_pkg;

    localparam int DEF_IR_W    = 2;
    localparam int DEF_DR_W    = 38;
    localparam int DEF_NUM_CMD = 2 ** DEF_IR_W;

    // Command word as captured from the virtual-JTAG chain at default widths
    typedef struct packed {
        logic [DEF_IR_W-1:0] ir;
        logic [DEF_DR_W-1:0] dr;
    } jtag_cmd_t;

    // Occupancy counter width: must represent 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Pointer width: indexes 0..depth-1, wraps modulo depth
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector.
// Chain and edge register reset to 0, so a level already high at reset
// release is reported as one rising edge once it reaches the chain output.
module jtag_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   level_last;

    // Shift the asynchronous level through the chain and remember the last synchronised level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p     <= '0;
            level_last <= 1'b0;
        end else begin
            sync_p     <= {sync_p[SYNC_STAGES-2:0], async_in};
            level_last <= sync_p[SYNC_STAGES-1];
        end
    end

    assign rise = sync_p[SYNC_STAGES-1] & ~level_last;

endmodule

// File: rtl/jtag_debug_cmd_bridge.sv
// System-clock side of the JTAG debug module: synchronises update strobes,
// buffers captured {ir, dr} commands in a small FIFO, hands them to the
// OCI core over valid/ready and decodes each accepted command into
// one-hot take-action / take-no-action pulses.
module jtag_debug_cmd_bridge
    import jtag_debug_pkg::*;
#(
    parameter  int IR_W        = DEF_IR_W,
    parameter  int DR_W        = DEF_DR_W,
    parameter  int ACT_BIT     = 35,
    parameter  int SYNC_STAGES = 2,
    parameter  int FIFO_DEPTH  = 4,
    localparam int NUM_CMD     = 2 ** IR_W,
    localparam int CNT_W       = cnt_w(FIFO_DEPTH),
    localparam int PTR_W       = ptr_w(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               vs_udr,
    input  logic               vs_uir,
    input  logic [IR_W-1:0]    ir_in,
    input  logic [DR_W-1:0]    sr,
    input  logic               cmd_ready,
    input  logic               ovf_clr,
    output logic               cmd_valid,
    output logic [DR_W-1:0]    jdo,
    output logic [IR_W-1:0]    cmd_ir,
    output logic               cmd_act,
    output logic [NUM_CMD-1:0] take_action,
    output logic [NUM_CMD-1:0] take_no_action,
    output logic               ir_update,
    output logic               overflow,
    output logic [CNT_W-1:0]   fifo_count
);

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [DR_W-1:0] dr;
    } cmd_t;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    cmd_t             mem [FIFO_DEPTH];
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             udr_stb;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             ovf_event;

    jtag_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_udr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_in(vs_udr),
        .rise    (udr_stb)
    );

    jtag_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_uir_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_in(vs_uir),
        .rise    (ir_update)
    );

    // Head-of-queue view; valid only reflects the registered count, so a fresh push never bypasses
    assign cmd_valid  = (count != '0);
    assign head       = mem[rd_ptr];
    assign jdo        = head.dr;
    assign cmd_ir     = head.ir;
    assign cmd_act    = head.dr[ACT_BIT];
    assign fifo_count = count;

    // Handshake decode: a full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        full      = (count == FULL_COUNT);
        pop       = cmd_valid & cmd_ready;
        push_ok   = udr_stb & (~full | pop);
        ovf_event = udr_stb & full & ~pop;
    end

    // Command storage; cleared on reset so the head reads 0 when nothing has been captured
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= '{ir: ir_in, dr: sr};
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracked separately to tell full from empty
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a dropped command wins over a clear in the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (ovf_event) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // One-cycle one-hot decode of the command accepted on this edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (pop) begin
                if (cmd_act) begin
                    take_action <= NUM_CMD'(1) << cmd_ir;
                end else begin
                    take_no_action <= NUM_CMD'(1) << cmd_ir;
                end
            end
        end
    end

endmodule
